// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-ported register file.
package reg_file_mp_pkg;

  localparam int unsigned max_ports_lp      = 16;
  localparam int unsigned port_idx_width_lp = 4;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  typedef struct packed {
    logic                         hit;
    logic [port_idx_width_lp-1:0] idx;
  } port_match_t;

  // Highest set bit of a write-port match mask; the last port wins on conflicts.
  function automatic port_match_t highest_match(input logic [max_ports_lp-1:0] mask);
    port_match_t m;
    m = '0;
    for (int i = 0; i < int'(max_ports_lp); i++) begin
      if (mask[i]) begin
        m.hit = 1'b1;
        m.idx = port_idx_width_lp'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register pending bits: reserve sets, write clears, reserve wins on collision.
module reg_file_scoreboard #(
  parameter int unsigned addr_width_p  = 6,
  parameter int unsigned write_ports_p = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n_i,
  input  logic                                       clear_i,
  input  logic                                       rsv_en_i,
  input  logic [addr_width_p-1:0]                    rsv_addr_i,
  input  logic [write_ports_p-1:0]                   w_en_i,
  input  logic [write_ports_p-1:0][addr_width_p-1:0] w_addr_i,
  output logic [(2**addr_width_p)-1:0]               pending_o
);

  localparam int unsigned depth_lp = 2**addr_width_p;

  logic [depth_lp-1:0] pend_q;
  logic [depth_lp-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < int'(write_ports_p); j++) begin
      if (w_en_i[j]) pend_d[w_addr_i[j]] = 1'b0;
    end
    if (rsv_en_i) pend_d[rsv_addr_i] = 1'b1;
    if (clear_i)  pend_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with bypass, zero register, pending scoreboard
// and a sequential clear sweep that keeps storage a reset-free array.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned addr_width_p  = 6,
  parameter int unsigned data_width_p  = 32,
  parameter int unsigned read_ports_p  = 2,
  parameter int unsigned write_ports_p = 2,
  parameter int unsigned bypass_p      = 1,
  parameter int unsigned zero_reg_p    = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n_i,
  input  logic                                       clear_i,
  input  logic [read_ports_p-1:0][addr_width_p-1:0]  r_addr_i,
  output logic [read_ports_p-1:0][data_width_p-1:0]  r_data_o,
  output logic [read_ports_p-1:0]                    r_ready_o,
  input  logic [write_ports_p-1:0]                   w_en_i,
  input  logic [write_ports_p-1:0][addr_width_p-1:0] w_addr_i,
  input  logic [write_ports_p-1:0][data_width_p-1:0] w_data_i,
  input  logic                                       rsv_en_i,
  input  logic [addr_width_p-1:0]                    rsv_addr_i,
  output logic                                       init_done_o
);

  localparam int unsigned depth_lp   = 2**addr_width_p;
  localparam bit          zero_en_lp = (zero_reg_p != 0);
  localparam bit          bypass_lp  = (bypass_p != 0);
  localparam logic [addr_width_p-1:0] last_addr_lp = addr_width_p'(depth_lp - 1);

  rf_state_e                state_q, state_d;
  logic [addr_width_p-1:0]  cnt_q, cnt_d;
  logic [data_width_p-1:0]  mem_q [depth_lp];
  logic [write_ports_p-1:0] w_valid;
  logic                     rsv_valid;
  logic [depth_lp-1:0]      pending;
  logic                     ready_st;

  assign ready_st    = (state_q == RF_READY);
  assign init_done_o = ready_st;

  // Clear sweep: one address per cycle, restartable by clear_i.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        cnt_d = cnt_q + addr_width_p'(1);
        if (cnt_q == last_addr_lp) state_d = RF_READY;
      end
      RF_READY: ;
      default:  state_d = RF_CLEAR;
    endcase
    if (clear_i) begin
      state_d = RF_CLEAR;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // User writes/reserves only count when the file is usable and not being cleared.
  always_comb begin
    for (int j = 0; j < int'(write_ports_p); j++) begin
      w_valid[j] = ready_st && !clear_i && w_en_i[j] &&
                   !(zero_en_lp && (w_addr_i[j] == '0));
    end
    rsv_valid = ready_st && !clear_i && rsv_en_i &&
                !(zero_en_lp && (rsv_addr_i == '0));
  end

  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < int'(write_ports_p); j++) begin
        if (w_valid[j]) mem_q[w_addr_i[j]] <= w_data_i[j];
      end
    end
  end

  reg_file_scoreboard #(
    .addr_width_p  (addr_width_p),
    .write_ports_p (write_ports_p)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n_i    (rst_n_i),
    .clear_i    (clear_i),
    .rsv_en_i   (rsv_valid),
    .rsv_addr_i (rsv_addr_i),
    .w_en_i     (w_valid),
    .w_addr_i   (w_addr_i),
    .pending_o  (pending)
  );

  for (genvar k = 0; k < int'(read_ports_p); k++) begin : g_rd
    logic [max_ports_lp-1:0] hit_mask;
    port_match_t             hit;
    logic [data_width_p-1:0] rd_data;
    logic                    rd_ready;

    always_comb begin
      hit_mask = '0;
      for (int j = 0; j < int'(write_ports_p); j++) begin
        hit_mask[j] = w_valid[j] && (w_addr_i[j] == r_addr_i[k]);
      end
      hit = highest_match(hit_mask);
    end

    // Zero register first, then storage with optional same-cycle forwarding.
    always_comb begin
      rd_data  = '0;
      rd_ready = 1'b0;
      if (ready_st) begin
        if (zero_en_lp && (r_addr_i[k] == '0)) begin
          rd_ready = 1'b1;
        end else begin
          rd_data  = mem_q[r_addr_i[k]];
          rd_ready = ~pending[r_addr_i[k]];
          if (bypass_lp && hit.hit) begin
            rd_ready = 1'b1;
            for (int j = 0; j < int'(write_ports_p); j++) begin
              if (hit.idx == port_idx_width_lp'(j)) rd_data = w_data_i[j];
            end
          end
        end
      end
    end

    assign r_data_o[k]  = rd_data;
    assign r_ready_o[k] = rd_ready;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing instance and one without bypass.
module tb_reg_file_mp;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic [1:0][5:0]   r_addr;
  logic [1:0][31:0]  r_data, r_data_nb;
  logic [1:0]        r_ready, r_ready_nb;
  logic [1:0]        w_en;
  logic [1:0][5:0]   w_addr;
  logic [1:0][31:0]  w_data;
  logic              rsv_en;
  logic [5:0]        rsv_addr;
  logic              init_done, init_done_nb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.bypass_p(1)) dut (
    .clk(clk), .rst_n_i(rst_n), .clear_i(clear),
    .r_addr_i(r_addr), .r_data_o(r_data), .r_ready_o(r_ready),
    .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .init_done_o(init_done)
  );

  reg_file_mp #(.bypass_p(0)) dut_nb (
    .clk(clk), .rst_n_i(rst_n), .clear_i(clear),
    .r_addr_i(r_addr), .r_data_o(r_data_nb), .r_ready_o(r_ready_nb),
    .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .init_done_o(init_done_nb)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    clear    = 1'b0;
    w_en     = '0;
    w_addr   = '0;
    w_data   = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  // Called at a negedge right after a sweep starts; counts edges until init_done.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk(tag, 64'(n), 64'd64);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc;
    logic        rdy;
    int          n;

    rst_n  = 1'b0;
    r_addr = '0;
    idle();
    #1;
    chk("rst_done", 64'(init_done), 64'd0);
    chk("rst_ready", 64'(r_ready), 64'd0);
    chk("rst_data", 64'(r_data[0]), 64'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("rst_sweep_len");
    chk("nb_done", 64'(init_done_nb), 64'd1);

    acc = '0;
    rdy = 1'b1;
    for (int a = 0; a < 64; a++) begin
      r_addr[0] = 6'(a);
      r_addr[1] = 6'(63 - a);
      #1;
      acc = acc | r_data[0] | r_data[1] | r_data_nb[0];
      rdy = rdy & (&r_ready) & (&r_ready_nb);
    end
    chk("sweep_zero", 64'(acc), 64'd0);
    chk("sweep_ready", 64'(rdy), 64'd1);

    // Write then read, with and without forwarding
    @(negedge clk);
    w_en = 2'b01; w_addr[0] = 6'd5; w_data[0] = 32'hDEADBEEF; r_addr[1] = 6'd5;
    #1;
    chk("byp_same", 64'(r_data[1]), 64'hDEADBEEF);
    chk("nobyp_same", 64'(r_data_nb[1]), 64'h0);
    @(negedge clk);
    idle();
    #1;
    chk("wr_rd", 64'(r_data[1]), 64'hDEADBEEF);
    chk("wr_rd_nb", 64'(r_data_nb[1]), 64'hDEADBEEF);

    // Write-port conflict
    @(negedge clk);
    w_en = 2'b11; w_addr[0] = 6'd7; w_addr[1] = 6'd7;
    w_data[0] = 32'h11; w_data[1] = 32'h22; r_addr[0] = 6'd7;
    #1;
    chk("conf_byp", 64'(r_data[0]), 64'h22);
    @(negedge clk);
    idle();
    #1;
    chk("conf_rd", 64'(r_data[0]), 64'h22);
    chk("conf_rd_nb", 64'(r_data_nb[0]), 64'h22);

    // Zero register
    @(negedge clk);
    w_en = 2'b01; w_addr[0] = 6'd0; w_data[0] = 32'hFFFF; r_addr[0] = 6'd0;
    #1;
    chk("zero_byp", 64'(r_data[0]), 64'h0);
    @(negedge clk);
    idle();
    rsv_en = 1'b1; rsv_addr = 6'd0;
    #1;
    chk("zero_rd_nb", 64'(r_data_nb[0]), 64'h0);
    @(negedge clk);
    idle();
    #1;
    chk("zero_rsv_ready", 64'(r_ready[0]), 64'd1);
    chk("zero_rsv_ready_nb", 64'(r_ready_nb[0]), 64'd1);

    // Scoreboard
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 6'd3; r_addr[0] = 6'd3;
    #1;
    chk("rsv_pre", 64'(r_ready[0]), 64'd1);
    @(negedge clk);
    idle();
    #1;
    chk("rsv_pend", 64'(r_ready[0]), 64'd0);
    chk("rsv_pend_nb", 64'(r_ready_nb[0]), 64'd0);
    @(negedge clk);
    w_en = 2'b01; w_addr[0] = 6'd3; w_data[0] = 32'h33;
    #1;
    chk("wr_ready_byp", 64'(r_ready[0]), 64'd1);
    chk("wr_ready_nb_same", 64'(r_ready_nb[0]), 64'd0);
    @(negedge clk);
    idle();
    #1;
    chk("wr_ready_nb", 64'(r_ready_nb[0]), 64'd1);
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 6'd3;
    w_en = 2'b10; w_addr[1] = 6'd3; w_data[1] = 32'h44;
    @(negedge clk);
    idle();
    #1;
    chk("rsv_wins", 64'(r_ready[0]), 64'd0);
    chk("rsv_wins_nb", 64'(r_ready_nb[0]), 64'd0);
    chk("rsv_wins_data", 64'(r_data[0]), 64'h44);

    // Clear mid-operation; write and reserve during the sweep are lost
    @(negedge clk);
    clear = 1'b1; r_addr[0] = 6'd3; r_addr[1] = 6'd5;
    @(negedge clk);
    idle();
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      #1;
      if (n == 3) begin
        chk("clr_data", 64'(r_data[1]), 64'h0);
        chk("clr_ready", 64'(r_ready[0]), 64'd0);
        chk("clr_done", 64'(init_done), 64'd0);
      end
      if (n == 20) begin
        w_en = 2'b01; w_addr[0] = 6'd2; w_data[0] = 32'h1234;
        rsv_en = 1'b1; rsv_addr = 6'd4;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      idle();
    end
    chk("clr_sweep_len", 64'(n), 64'd64);
    r_addr[0] = 6'd2; r_addr[1] = 6'd5;
    #1;
    chk("clr_lost_wr", 64'(r_data[0]), 64'h0);
    chk("clr_old_data", 64'(r_data_nb[1]), 64'h0);
    r_addr[0] = 6'd3; r_addr[1] = 6'd4;
    #1;
    chk("clr_pend3", 64'(r_ready[0]), 64'd1);
    chk("clr_lost_rsv", 64'(r_ready_nb[1]), 64'd1);

    // Asynchronous reset mid-operation, then mid-sweep
    @(negedge clk);
    r_addr[0] = 6'd0;
    #1;
    chk("pre_rst_zero_ready", 64'(r_ready[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_done", 64'(init_done), 64'd0);
    chk("async_rst_ready", 64'(r_ready[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", 64'(init_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("mid_rst_sweep_len");

    // Usable again after the restarted sweep
    w_en = 2'b10; w_addr[1] = 6'd10; w_data[1] = 32'hCAFE0001; r_addr[0] = 6'd10;
    @(negedge clk);
    idle();
    #1;
    chk("post_rst_rd", 64'(r_data[0]), 64'hCAFE0001);
    chk("post_rst_rd_nb", 64'(r_data_nb[0]), 64'hCAFE0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
